// File: rtl/bank_ram_pkg.sv
// Shared defaults and FSM state encoding for bank_ram_ctrl.
// RD_OUT exists only when BANK_RAM_RDATA_REG_EN is defined (registered read return).
package bank_ram_pkg;

  localparam int NUM_BANKS_DEF  = 5;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_DATA    = 3'd1,
    ST_RD_ISSUE   = 3'd2,
    ST_RD_CAPTURE = 3'd3
`ifdef BANK_RAM_RDATA_REG_EN
    , ST_RD_OUT   = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/bank_ram_rd_path.sv
// Read-return path: zeroes lanes of unaddressed banks and drives rdata while rvalid.
// With BANK_RAM_RDATA_REG_EN defined the masked word is captured into a flop first.
module bank_ram_rd_path
  import bank_ram_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture,
  input  logic                          rvalid,
  input  logic [NUM_BANKS-1:0]          mask,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);

  logic [NUM_BANKS*DATA_WIDTH-1:0] masked;

  always_comb begin
    masked = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (mask[b]) begin
        masked[b*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef BANK_RAM_RDATA_REG_EN
  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata_d;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (capture) begin
      rdata_d = masked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rvalid ? rdata_q : '0;
`else
  // Combinational return: the clock, reset and capture strobe have no job here.
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, capture};

  assign rdata = rvalid ? masked : '0;
`endif

endmodule

// File: rtl/bank_ram_ctrl.sv
// Single-outstanding command controller for a row of NUM_BANKS SRAM banks sharing one address.
// Define BANK_RAM_RDATA_REG_EN to register read data (rvalid one cycle later, from a flop).
module bank_ram_ctrl
  import bank_ram_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rw,
  input  logic [NUM_BANKS-1:0]            cmd_mask,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic                            wvalid,
  output logic                            wready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  output logic                            rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_BANKS-1:0]            bank_ce,
  output logic [NUM_BANKS-1:0]            bank_we,
  output logic [ADDR_WIDTH-1:0]           bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata
);

  state_t                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [NUM_BANKS-1:0]  mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  capture;

  // Reset is synchronous but must silence every output in the very cycle it is high,
  // so the combinational block overrides all outputs while rst is asserted.
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    cmd_ready  = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    capture    = 1'b0;
    bank_ce    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          mask_d  = cmd_mask;
          addr_d  = cmd_addr;
          state_d = cmd_rw ? ST_WR_DATA : ST_RD_ISSUE;
        end
      end
      ST_WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          bank_ce    = mask_q;
          bank_we    = mask_q;
          bank_addr  = addr_q;
          bank_wdata = wdata;
          state_d    = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        bank_ce   = mask_q;
        bank_addr = addr_q;
        state_d   = ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: begin
`ifdef BANK_RAM_RDATA_REG_EN
        capture = 1'b1;
        state_d = ST_RD_OUT;
`else
        rvalid  = 1'b1;
        state_d = ST_IDLE;
`endif
      end
`ifdef BANK_RAM_RDATA_REG_EN
      ST_RD_OUT: begin
        rvalid  = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      state_d    = ST_IDLE;
      cmd_ready  = 1'b0;
      wready     = 1'b0;
      rvalid     = 1'b0;
      capture    = 1'b0;
      bank_ce    = '0;
      bank_we    = '0;
      bank_addr  = '0;
      bank_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
    end
  end

  bank_ram_rd_path #(
    .NUM_BANKS  (NUM_BANKS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_path (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .rvalid     (rvalid),
    .mask       (mask_q),
    .bank_rdata (bank_rdata),
    .rdata      (rdata)
  );

  // Latched direction is kept for debug visibility; the FSM state already encodes it.
  logic unused_rw;
  assign unused_rw = rw_q;

endmodule

// File: tb/tb_bank_ram_ctrl.sv
// Self-checking bench for bank_ram_ctrl: behavioural SRAM on the bank port plus a
// word-array reference of what each bank should hold; honours BANK_RAM_RDATA_REG_EN.
module tb_bank_ram_ctrl;

  localparam int NB  = 5;
  localparam int AW  = 9;
  localparam int DW  = 32;
`ifdef BANK_RAM_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_rw;
  logic [NB-1:0]     cmd_mask;
  logic [AW-1:0]     cmd_addr;
  logic              wvalid, wready;
  logic [NB*DW-1:0]  wdata;
  logic              rvalid;
  logic [NB*DW-1:0]  rdata;
  logic [NB-1:0]     bank_ce, bank_we;
  logic [AW-1:0]     bank_addr;
  logic [NB*DW-1:0]  bank_wdata;
  logic [NB*DW-1:0]  bank_rdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sram    [NB][512];
  logic [DW-1:0] exp_mem [NB][512];

  bank_ram_ctrl #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_mask(cmd_mask), .cmd_addr(cmd_addr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rdata(rdata),
    .bank_ce(bank_ce), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural banks: write on ce&we, read data appears the cycle after ce with we=0.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_ce[b]) begin
        if (bank_we[b]) sram[b][bank_addr] <= bank_wdata[b*DW +: DW];
        else            bank_rdata[b*DW +: DW] <= sram[b][bank_addr];
      end
    end
  end

  function automatic logic [NB*DW-1:0] expect_rdata(input logic [NB-1:0] m, input logic [AW-1:0] a);
    logic [NB*DW-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) if (m[b]) r[b*DW +: DW] = exp_mem[b][a];
    return r;
  endfunction

  function automatic logic [NB*DW-1:0] random_words();
    logic [NB*DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_mask = '1; cmd_addr = 9'h1aa;
    wvalid = 1'b1; wdata = random_words();
    step();
    step();
    #1;
    checks++;
    if ({cmd_ready, wready, rvalid, rdata, bank_ce, bank_we, bank_addr, bank_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ready=%b wready=%b rvalid=%b ce=%b we=%b addr=%h, required all zero",
               cmd_ready, wready, rvalid, bank_ce, bank_we, bank_addr);
    end
    rst = 1'b0; cmd_valid = 1'b0; wvalid = 1'b0;
    step();
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b, required 1", cmd_ready);
    end
    step();
  endtask

  // Issues one write with 'gap' idle data cycles before the beat, then checks the return to idle.
  task automatic do_write(input logic [NB-1:0] m, input logic [AW-1:0] a,
                          input logic [NB*DW-1:0] d, input int gap);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_mask = m; cmd_addr = a; wvalid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_cmd_ready: got %b, required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0; cmd_mask = '0; cmd_addr = '0;
    for (int i = 0; i < gap; i++) begin
      #1;
      checks++;
      if ({cmd_ready, wready, bank_ce, bank_we} !== {1'b0, 1'b1, {2*NB{1'b0}}}) begin
        errors++;
        $display("[TB] FAIL wr_wait: ready=%b wready=%b ce=%b we=%b, required 0 1 0 0",
                 cmd_ready, wready, bank_ce, bank_we);
      end
      step();
    end
    wvalid = 1'b1; wdata = d;
    #1;
    checks++;
    if ({bank_ce, bank_we, bank_addr, bank_wdata, wready} !== {m, m, a, d, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wr_beat: ce=%b we=%b addr=%h wready=%b, required ce=we=%b addr=%h wready=1 wdata match=%b",
               bank_ce, bank_we, bank_addr, wready, m, a, bank_wdata === d);
    end
    for (int b = 0; b < NB; b++) if (m[b]) exp_mem[b][a] = d[b*DW +: DW];
    step();
    wvalid = 1'b0; wdata = random_words();
    #1;
    checks++;
    if ({cmd_ready, wready, bank_ce} !== {1'b1, 1'b0, {NB{1'b0}}}) begin
      errors++;
      $display("[TB] FAIL wr_done: ready=%b wready=%b ce=%b, required 1 0 0", cmd_ready, wready, bank_ce);
    end
    step();
  endtask

  task automatic do_read(input logic [NB-1:0] m, input logic [AW-1:0] a);
    logic [NB-1:0]    exp_ce;
    logic [NB*DW-1:0] exp_d;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_mask = m; cmd_addr = a;
    wvalid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd_cmd_ready: got %b, required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0; cmd_mask = '0; cmd_addr = '0;
    exp_d = expect_rdata(m, a);
    for (int k = 1; k <= LAT; k++) begin
      #1;
      exp_ce = (k == 1) ? m : '0;
      checks++;
      if ({bank_ce, bank_we, rvalid, cmd_ready, wready} !== {exp_ce, {NB{1'b0}}, (k == LAT), 2'b00}) begin
        errors++;
        $display("[TB] FAIL rd_cycle%0d: ce=%b we=%b rvalid=%b ready=%b wready=%b, required ce=%b we=0 rvalid=%b ready=0 wready=0",
                 k, bank_ce, bank_we, rvalid, cmd_ready, wready, exp_ce, (k == LAT));
      end
      if (k == 1 && m != '0) begin
        checks++;
        if (bank_addr !== a) begin
          errors++;
          $display("[TB] FAIL rd_addr: got %h, required %h", bank_addr, a);
        end
      end
      if (k == LAT) begin
        checks++;
        if (rdata !== exp_d) begin
          errors++;
          $display("[TB] FAIL rd_data: got %h, required %h", rdata, exp_d);
        end
      end
      step();
    end
    wvalid = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rvalid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rd_done: ready=%b rvalid=%b, required 1 0", cmd_ready, rvalid);
    end
    step();
  endtask

  task automatic test_directed();
    logic [NB*DW-1:0] d;
    d = '0;
    for (int b = 0; b < NB; b++) d[b*DW +: DW] = 32'h11 * (b + 1);
    do_write(5'b10101, 9'h012, d, 0);
    do_read(5'b11111, 9'h012);
  endtask

  task automatic test_write_stall();
    do_write(5'b01010, 9'h0a5, random_words(), 10);
    do_read(5'b01110, 9'h0a5);
  endtask

  task automatic test_zero_mask();
    do_write(5'b00000, 9'h012, random_words(), 2);
    do_read(5'b00000, 9'h012);
    do_read(5'b11111, 9'h012);
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_mask = 5'b11111; cmd_addr = 9'h012;
    step();
    cmd_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, wready, rvalid, rdata, bank_ce, bank_we, bank_addr, bank_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_read_outputs: ready=%b rvalid=%b ce=%b we=%b addr=%h, required all zero",
               cmd_ready, rvalid, bank_ce, bank_we, bank_addr);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({cmd_ready, rvalid, bank_ce} !== {1'b1, 1'b0, {NB{1'b0}}}) begin
        errors++;
        $display("[TB] FAIL rst_mid_read_after%0d: ready=%b rvalid=%b ce=%b, required 1 0 0",
                 k, cmd_ready, rvalid, bank_ce);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_write();
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_mask = 5'b11111; cmd_addr = 9'h012;
    step();
    cmd_valid = 1'b0; rst = 1'b1; wvalid = 1'b1; wdata = random_words();
    #1;
    checks++;
    if ({bank_ce, bank_we, wready} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_write_strobe: ce=%b we=%b wready=%b, required 0", bank_ce, bank_we, wready);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bank_ce, bank_we, wready, cmd_ready} !== {{2*NB{1'b0}}, 2'b01}) begin
        errors++;
        $display("[TB] FAIL rst_mid_write_after%0d: ce=%b we=%b wready=%b ready=%b, required 0 0 0 1",
                 k, bank_ce, bank_we, wready, cmd_ready);
      end
      step();
    end
    wvalid = 1'b0;
    do_read(5'b11111, 9'h012);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: a = 9'h012;
        1: a = 9'h0a5;
        2: a = 9'h1ff;
        default: a = 9'h000;
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(NB'($urandom), a, random_words(), int'($urandom_range(0, 3)));
      else
        do_read(NB'($urandom), a);
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 512; i++) begin
        sram[b][i]    = '0;
        exp_mem[b][i] = '0;
      end
    bank_rdata = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_mask = '0; cmd_addr = '0;
    wvalid = 1'b0; wdata = '0;
    #1;
    test_reset();
    test_directed();
    test_write_stall();
    test_zero_mask();
    test_reset_mid_read();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
